ika87ad_opfetch: RTL and testbench
==================================

Name: ika87ad_opfetch

Overview:
- Opcode fetch and prefix sequencer for the IKA87AD core.
- Consumes instruction bytes from the fetch bus and recognises the prefix bytes 0x48, 0x60, 0x64, 0x70 and 0x74.
- Delivers each assembled opcode byte with its 3-bit opcode page to the opcode decoder and microsequencer through a valid/ack handshake.
- Injects the hardware-interrupt pseudo-opcode at instruction boundaries.

Parameters:
- P_HARDI_OP, 8'h73, opcode emitted (page 0) on interrupt injection.
- P_INT_EN, 1, 1 = interrupt injection enabled; 0 = i_INT_REQ ignored and o_INT_ACK tied low.

Ports:
- i_EMUCLK  in  1  system clock; all state on rising edge.
- i_RST_n  in  1  asynchronous active-low reset.
- i_FLUSH  in  1  redirect (jump/branch/reset of PC); discard partial or pending opcode.
- i_BYTE  in  8  fetched instruction byte.
- i_BYTE_VALID  in  1  i_BYTE valid this cycle.
- o_BYTE_REQ  out  1  fetch ready; byte accepted when o_BYTE_REQ & i_BYTE_VALID.
- o_PC_INC  out  1  one-cycle pulse, cycle after each accepted byte.
- o_M1  out  1  high while waiting for the first byte of an instruction.
- i_INT_REQ  in  1  pending hardware interrupt (level).
- o_INT_ACK  out  1  one-cycle pulse when the interrupt is injected.
- o_OPCODE  out  8  opcode byte (second byte if prefixed).
- o_OPCODE_PAGE  out  3  0 plain; 1=0x48, 2=0x60, 3=0x64, 4=0x70, 5=0x74.
- o_OPLEN  out  2  opcode bytes consumed: 0 injected, 1 plain, 2 prefixed.
- o_OP_VALID  out  1  opcode/page/len valid; held until acked.
- i_OP_ACK  in  1  consumer accepts opcode.

Behaviour:
- Reset (async, i_RST_n=0) sets the following, released synchronously on the next edge:
  - state S_OP1;
  - o_OPCODE=8'h00, o_OPCODE_PAGE=0, o_OPLEN=0;
  - o_OP_VALID=0, o_PC_INC=0, o_INT_ACK=0.
- States are S_OP1 (first byte), S_OP2 (post-prefix byte) and S_OUT (holding output).
- o_BYTE_REQ is combinational:
  - equals (S_OP1 & ~(P_INT_EN & i_INT_REQ)) | S_OP2;
  - forced 0 while i_FLUSH=1.
- o_M1 = S_OP1. o_OP_VALID = S_OUT.
- S_OP1, in priority order:
  - i_FLUSH: stay.
  - P_INT_EN & i_INT_REQ: load o_OPCODE=P_HARDI_OP, page 0, len 0; pulse o_INT_ACK; go S_OUT; no byte consumed.
  - Byte accepted and it is a prefix: latch its page internally; go S_OP2.
  - Byte accepted and not a prefix: o_OPCODE=byte, page 0, len 1; go S_OUT.
- S_OP2:
  - Interrupts are not sampled (never split a prefixed instruction).
  - Accepted byte: o_OPCODE=byte, page=latched, len 2; go S_OUT.
  - Any byte value, including prefix codes, is a plain opcode here.
- S_OUT:
  - Outputs are stable.
  - On i_OP_ACK go S_OP1; the next fetch request appears the cycle after the ack edge.
- o_PC_INC:
  - registered, high for exactly one cycle after each accepted byte;
  - never for injected opcodes;
  - still pulses for a byte accepted before a flush.
- Latency:
  - plain byte accepted at edge N gives o_OP_VALID high from cycle N+1;
  - prefixed pair accepted at edges N and M gives valid from cycle M+1.
- i_FLUSH (synchronous) has top priority in every state:
  - go S_OP1, clear latched page, o_OP_VALID=0;
  - no byte is accepted in a flush cycle;
  - flush beats a simultaneous i_OP_ACK or i_INT_REQ;
  - output data registers keep their old values.
- i_OP_ACK outside S_OUT is ignored.
- i_BYTE_VALID while o_BYTE_REQ=0: byte not consumed; the source holds it.
- Injected interrupt with i_INT_REQ still high after the ack:
  - re-injects only if still asserted in S_OP1;
  - the interrupt controller must deassert after o_INT_ACK.

Test Plan:
1. Reset, then bytes 0x54 (valid each cycle), ack on first valid:
   - o_OPCODE=0x54, page 0, len 1, valid one cycle after acceptance;
   - one o_PC_INC pulse.
2. Bytes 0x48,0x3A:
   - after 0x48, o_M1=0 and no valid;
   - then o_OPCODE=0x3A, page 1, len 2;
   - two o_PC_INC pulses.
3. Bytes 0x74,0x74, then 0x70,0x48 (acks between):
   - first opcode 0x74 page 5;
   - second opcode 0x48 page 4;
   - prefix codes in S_OP2 are not re-treated as prefixes.
4. i_INT_REQ=1 in S_OP1 with i_BYTE_VALID=1, i_BYTE=0x00:
   - o_BYTE_REQ=0, o_INT_ACK pulse;
   - o_OPCODE=0x73 page 0 len 0;
   - no o_PC_INC, and byte 0x00 is fetched after ack.
5. Hold i_INT_REQ=1 after accepting 0x60 (S_OP2), then byte 0x9A:
   - o_OPCODE=0x9A page 2 delivered first;
   - the interrupt is injected on the next S_OP1.
6. Accept 0x64, then i_FLUSH=1 together with i_BYTE_VALID:
   - byte not accepted, o_OP_VALID stays 0;
   - next byte 0x06 yields page 0 (prefix discarded);
   - also assert i_RST_n low mid-S_OUT: valid drops immediately without a clock.

Source files
------------

// File: rtl/ika87ad_opfetch.sv
// IKA87AD opcode fetch and prefix sequencer.
// Assembles opcode bytes with their page and injects the interrupt opcode.
module ika87ad_opfetch #(
  parameter logic [7:0] P_HARDI_OP = 8'h73,
  parameter bit         P_INT_EN   = 1'b1
) (
  input  logic       i_EMUCLK,
  input  logic       i_RST_n,
  input  logic       i_FLUSH,
  input  logic [7:0] i_BYTE,
  input  logic       i_BYTE_VALID,
  output logic       o_BYTE_REQ,
  output logic       o_PC_INC,
  output logic       o_M1,
  input  logic       i_INT_REQ,
  output logic       o_INT_ACK,
  output logic [7:0] o_OPCODE,
  output logic [2:0] o_OPCODE_PAGE,
  output logic [1:0] o_OPLEN,
  output logic       o_OP_VALID,
  input  logic       i_OP_ACK
);

  typedef enum logic [1:0] {
    S_OP1,
    S_OP2,
    S_OUT
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] opcode_q, opcode_d;
  logic [2:0] page_q, page_d;
  logic [1:0] len_q, len_d;
  logic [2:0] pfx_q, pfx_d;
  logic       pc_inc_q, pc_inc_d;
  logic       int_ack_q, int_ack_d;

  logic       int_req;
  logic       byte_req;
  logic       accept;
  logic [2:0] byte_pg;

  assign int_req = P_INT_EN & i_INT_REQ;

  assign byte_req = ~i_FLUSH &
    (((state_q == S_OP1) & ~int_req) |
     (state_q == S_OP2));

  assign accept = byte_req & i_BYTE_VALID;

  always_comb begin
    case (i_BYTE)
      8'h48:   byte_pg = 3'd1;
      8'h60:   byte_pg = 3'd2;
      8'h64:   byte_pg = 3'd3;
      8'h70:   byte_pg = 3'd4;
      8'h74:   byte_pg = 3'd5;
      default: byte_pg = 3'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    opcode_d  = opcode_q;
    page_d    = page_q;
    len_d     = len_q;
    pfx_d     = pfx_q;
    pc_inc_d  = accept;
    int_ack_d = 1'b0;
    if (i_FLUSH) begin
      state_d = S_OP1;
      pfx_d   = 3'd0;
    end else begin
      unique case (state_q)
        S_OP1: begin
          if (int_req) begin
            opcode_d  = P_HARDI_OP;
            page_d    = 3'd0;
            len_d     = 2'd0;
            int_ack_d = 1'b1;
            state_d   = S_OUT;
          end else if (accept) begin
            if (byte_pg != 3'd0) begin
              pfx_d   = byte_pg;
              state_d = S_OP2;
            end else begin
              opcode_d = i_BYTE;
              page_d   = 3'd0;
              len_d    = 2'd1;
              state_d  = S_OUT;
            end
          end
        end
        S_OP2: begin
          // prefix codes are ordinary opcodes here
          if (accept) begin
            opcode_d = i_BYTE;
            page_d   = pfx_q;
            len_d    = 2'd2;
            state_d  = S_OUT;
          end
        end
        S_OUT: begin
          if (i_OP_ACK) state_d = S_OP1;
        end
        default: state_d = S_OP1;
      endcase
    end
  end

  always_ff @(posedge i_EMUCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      state_q   <= S_OP1;
      opcode_q  <= 8'h00;
      page_q    <= 3'd0;
      len_q     <= 2'd0;
      pfx_q     <= 3'd0;
      pc_inc_q  <= 1'b0;
      int_ack_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      opcode_q  <= opcode_d;
      page_q    <= page_d;
      len_q     <= len_d;
      pfx_q     <= pfx_d;
      pc_inc_q  <= pc_inc_d;
      int_ack_q <= int_ack_d;
    end
  end

  assign o_BYTE_REQ    = byte_req;
  assign o_PC_INC      = pc_inc_q;
  assign o_M1          = (state_q == S_OP1);
  assign o_INT_ACK     = int_ack_q;
  assign o_OPCODE      = opcode_q;
  assign o_OPCODE_PAGE = page_q;
  assign o_OPLEN       = len_q;
  assign o_OP_VALID    = (state_q == S_OUT);

endmodule

// File: tb/tb_ika87ad_opfetch.sv
// Testbench for ika87ad_opfetch: cycle vectors, corner
// sequences and a randomized byte stream against a parser model.
module tb_ika87ad_opfetch;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fl;
  logic [7:0] by;
  logic       bv;
  logic       breq;
  logic       pci;
  logic       m1;
  logic       ir;
  logic       iak;
  logic [7:0] op;
  logic [2:0] pg;
  logic [1:0] ln;
  logic       vld;
  logic       ak;

  int checks = 0;
  int errors = 0;

  ika87ad_opfetch dut (
    .i_EMUCLK      (clk),
    .i_RST_n       (rst_n),
    .i_FLUSH       (fl),
    .i_BYTE        (by),
    .i_BYTE_VALID  (bv),
    .o_BYTE_REQ    (breq),
    .o_PC_INC      (pci),
    .o_M1          (m1),
    .i_INT_REQ     (ir),
    .o_INT_ACK     (iak),
    .o_OPCODE      (op),
    .o_OPCODE_PAGE (pg),
    .o_OPLEN       (ln),
    .o_OP_VALID    (vld),
    .i_OP_ACK      (ak)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       fl;
    logic [7:0] by;
    logic       bv;
    logic       ir;
    logic       ak;
    logic       breq;
    logic       m1;
    logic       vld;
    logic [7:0] op;
    logic [2:0] pg;
    logic [1:0] ln;
    logic       pci;
    logic       iak;
  } vec_t;

  typedef struct {
    logic [7:0] op;
    logic [2:0] pg;
    logic [1:0] ln;
  } opx_t;

  vec_t v[29];

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", n, a, e);
    end
  endtask

  function automatic logic [2:0] pfx_page(input logic [7:0] b);
    logic [2:0] r;
    r = 3'd0;
    if (b == 8'h48) r = 3'd1;
    if (b == 8'h60) r = 3'd2;
    if (b == 8'h64) r = 3'd3;
    if (b == 8'h70) r = 3'd4;
    if (b == 8'h74) r = 3'd5;
    return r;
  endfunction

  initial begin
    logic [7:0] bytes[$];
    opx_t       expq[$];
    opx_t       e;
    logic [7:0] pfxl[5];
    int         idx;
    int         pulses;
    int         cyc;
    bit         acc;

    pfxl[0] = 8'h48; pfxl[1] = 8'h60; pfxl[2] = 8'h64;
    pfxl[3] = 8'h70; pfxl[4] = 8'h74;

    //      fl    by     bv ir ak  breq m1 vld op     pg ln pci iak
    v[0]  = '{1'b0, 8'h54, 1, 0, 0, 1, 1, 0, 8'h00, 0, 0, 0, 0};
    v[1]  = '{1'b0, 8'h54, 1, 0, 1, 0, 0, 1, 8'h54, 0, 1, 1, 0};
    v[2]  = '{1'b0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h54, 0, 1, 0, 0};
    v[3]  = '{1'b0, 8'h48, 1, 0, 0, 1, 1, 0, 8'h54, 0, 1, 0, 0};
    v[4]  = '{1'b0, 8'h3A, 1, 0, 0, 1, 0, 0, 8'h54, 0, 1, 1, 0};
    v[5]  = '{1'b0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h3A, 1, 2, 1, 0};
    v[6]  = '{1'b0, 8'h74, 1, 0, 0, 1, 1, 0, 8'h3A, 1, 2, 0, 0};
    v[7]  = '{1'b0, 8'h74, 1, 0, 0, 1, 0, 0, 8'h3A, 1, 2, 1, 0};
    v[8]  = '{1'b0, 8'h70, 1, 0, 1, 0, 0, 1, 8'h74, 5, 2, 1, 0};
    v[9]  = '{1'b0, 8'h70, 1, 0, 0, 1, 1, 0, 8'h74, 5, 2, 0, 0};
    v[10] = '{1'b0, 8'h48, 1, 0, 0, 1, 0, 0, 8'h74, 5, 2, 1, 0};
    v[11] = '{1'b0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h48, 4, 2, 1, 0};
    v[12] = '{1'b0, 8'h00, 1, 1, 0, 0, 1, 0, 8'h48, 4, 2, 0, 0};
    v[13] = '{1'b0, 8'h00, 1, 0, 0, 0, 0, 1, 8'h73, 0, 0, 0, 1};
    v[14] = '{1'b0, 8'h00, 1, 0, 1, 0, 0, 1, 8'h73, 0, 0, 0, 0};
    v[15] = '{1'b0, 8'h00, 1, 0, 0, 1, 1, 0, 8'h73, 0, 0, 0, 0};
    v[16] = '{1'b0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h00, 0, 1, 1, 0};
    v[17] = '{1'b0, 8'h60, 1, 0, 0, 1, 1, 0, 8'h00, 0, 1, 0, 0};
    v[18] = '{1'b0, 8'h9A, 1, 1, 0, 1, 0, 0, 8'h00, 0, 1, 1, 0};
    v[19] = '{1'b0, 8'h00, 0, 1, 1, 0, 0, 1, 8'h9A, 2, 2, 1, 0};
    v[20] = '{1'b0, 8'h00, 0, 1, 0, 0, 1, 0, 8'h9A, 2, 2, 0, 0};
    v[21] = '{1'b0, 8'h00, 0, 0, 1, 0, 0, 1, 8'h73, 0, 0, 0, 1};
    v[22] = '{1'b0, 8'h64, 1, 0, 0, 1, 1, 0, 8'h73, 0, 0, 0, 0};
    v[23] = '{1'b1, 8'h06, 1, 0, 0, 0, 0, 0, 8'h73, 0, 0, 1, 0};
    v[24] = '{1'b0, 8'h06, 1, 0, 0, 1, 1, 0, 8'h73, 0, 0, 0, 0};
    v[25] = '{1'b0, 8'h00, 0, 0, 0, 0, 0, 1, 8'h06, 0, 1, 1, 0};
    v[26] = '{1'b1, 8'h00, 0, 1, 1, 0, 0, 1, 8'h06, 0, 1, 0, 0};
    v[27] = '{1'b1, 8'h00, 0, 1, 0, 0, 1, 0, 8'h06, 0, 1, 0, 0};
    v[28] = '{1'b0, 8'h00, 0, 0, 0, 1, 1, 0, 8'h06, 0, 1, 0, 0};

    rst_n = 1'b0; fl = 0; by = 0; bv = 0; ir = 0; ak = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.vld", vld, 0);
    chk("rst.op", op, 8'h00);
    chk("rst.pg", pg, 0);
    chk("rst.ln", ln, 0);
    chk("rst.pci", pci, 0);
    chk("rst.iak", iak, 0);
    chk("rst.m1", m1, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 29; i++) begin
      fl = v[i].fl; by = v[i].by; bv = v[i].bv;
      ir = v[i].ir; ak = v[i].ak;
      #1;
      chk($sformatf("v%0d.breq", i), breq, v[i].breq);
      chk($sformatf("v%0d.m1", i), m1, v[i].m1);
      chk($sformatf("v%0d.vld", i), vld, v[i].vld);
      chk($sformatf("v%0d.op", i), op, v[i].op);
      chk($sformatf("v%0d.pg", i), pg, v[i].pg);
      chk($sformatf("v%0d.ln", i), ln, v[i].ln);
      chk($sformatf("v%0d.pci", i), pci, v[i].pci);
      chk($sformatf("v%0d.iak", i), iak, v[i].iak);
      @(posedge clk); #1;
    end

    // async reset while holding an opcode
    fl = 0; ir = 0; ak = 0; by = 8'h11; bv = 1;
    @(posedge clk); #1;
    bv = 0;
    chk("ar.vld_pre", vld, 1);
    chk("ar.op_pre", op, 8'h11);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.vld", vld, 0);
    chk("ar.op", op, 8'h00);
    chk("ar.m1", m1, 1);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // randomized stream parsed by a byte-level model
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 9) < 4)
        bytes.push_back(pfxl[$urandom_range(0, 4)]);
      else
        bytes.push_back(8'($urandom));
    end
    bytes.push_back(8'h01);
    for (int i = 0; i < bytes.size(); i++) begin
      if (pfx_page(bytes[i]) != 3'd0) begin
        e.op = bytes[i + 1];
        e.pg = pfx_page(bytes[i]);
        e.ln = 2'd2;
        i++;
      end else begin
        e.op = bytes[i];
        e.pg = 3'd0;
        e.ln = 2'd1;
      end
      expq.push_back(e);
    end

    idx = 0;
    pulses = 0;
    cyc = 0;
    while ((expq.size() != 0 || idx < bytes.size()) && cyc < 5000) begin
      bv = (idx < bytes.size()) && ($urandom_range(0, 2) != 0);
      by = (idx < bytes.size()) ? bytes[idx] : 8'h00;
      ak = ($urandom_range(0, 1) == 1);
      #1;
      acc = breq && bv;
      if (pci) pulses++;
      if (vld && ak) begin
        if (expq.size() == 0) begin
          chk("rnd.extra", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("rnd.op", op, e.op);
          chk("rnd.pg", pg, e.pg);
          chk("rnd.ln", ln, e.ln);
        end
      end
      @(posedge clk); #1;
      if (acc) idx++;
      cyc++;
    end
    bv = 0; ak = 0;
    #1;
    if (pci) pulses++;
    chk("rnd.timeout", (cyc < 5000), 1);
    chk("rnd.left", expq.size(), 0);
    chk("rnd.pcinc", pulses, bytes.size());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
